// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Adds two WIDTH-bit operands over WIDTH/4 cycles using one shared 4-bit
// ripple-carry slice. The carry between nibbles is kept in a register.
// There is a valid/ready handshake on the operand side and on the result side.
//
// Optional feature (compile-time macro NIBBLE_ADD_SUB_EN):
//   When the macro is defined, the sub port is present. With sub=1 the block
//   computes a - b. It does this by inverting the B nibbles and forcing the
//   initial carry to 1. In that mode cout=1 means no borrow.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand set valid
//   in_ready   out  block can accept an operand set (IDLE, not in reset)
//   a, b       in   WIDTH-bit operands
//   cin        in   initial carry-in
//   sub        in   subtract request (NIBBLE_ADD_SUB_EN only)
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   sum        out  WIDTH-bit result
//   cout       out  carry-out of the top nibble
//   busy       out  high while nibbles are being processed (RUN)
// ---------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int IW      = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef NIBBLE_ADD_SUB_EN
    logic             sub_q, sub_d;
`endif

    logic [IW-1:0]    base_s;
    logic [3:0]       slice_a_s;
    logic [3:0]       slice_b_s;
    logic [4:0]       slice_res_s;

    // The one 4-bit ripple-carry slice: {carry_out, sum[3:0]}.
    function automatic logic [4:0] slice_add(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       c);
        slice_add = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    endfunction

    // Select nibble k of the latched operands and feed it to the slice.
    always_comb begin
        base_s    = IW'({cnt_q, 2'b00});
        slice_a_s = a_q[base_s +: 4];
`ifdef NIBBLE_ADD_SUB_EN
        slice_b_s = sub_q ? ~b_q[base_s +: 4] : b_q[base_s +: 4];
`else
        slice_b_s = b_q[base_s +: 4];
`endif
        slice_res_s = slice_add(slice_a_s, slice_b_s, carry_q);
    end

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef NIBBLE_ADD_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
`ifdef NIBBLE_ADD_SUB_EN
                    sub_d   = sub;
                    // Two's-complement subtract: the +1 enters as the carry.
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[base_s +: 4] = slice_res_s[3:0];
                carry_d            = slice_res_s[4];
                if (cnt_q == LAST_NIB) begin
                    // The counter stays at the last nibble; only accept clears it.
                    cout_d  = slice_res_s[4];
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef NIBBLE_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // in_ready is held low while reset is asserted. The other outputs are
    // decoded from registered state.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
